// File: rtl/ppu_write_scheduler_pkg.sv
// ppu_pkg: shared types and timing constants for the PPU write scheduler.
//   tbl_sel_t     - target table of a queued write (attr, sprite, color, none)
//   tbl_wr_t      - one queued write: {sel, addr, data}
//   sched_state_t - commit scheduler states
//   sel_onehot    - maps a table select to the one-hot table write enable
package ppu_pkg;

  localparam int unsigned VACTIVE = 480;
  localparam int unsigned VTOTAL  = 525;

  typedef enum logic [1:0] {
    TBL_ATTR   = 2'b00,
    TBL_SPRITE = 2'b01,
    TBL_COLOR  = 2'b10,
    TBL_NONE   = 2'b11
  } tbl_sel_t;

  typedef struct packed {
    tbl_sel_t    sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } tbl_wr_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DRAIN
  } sched_state_t;

  // Bit 0 attr, bit 1 sprite, bit 2 color; TBL_NONE never reaches the write port.
  function automatic logic [2:0] sel_onehot(input tbl_sel_t sel);
    logic [2:0] we;
    we = '0;
    case (sel)
      TBL_ATTR:   we = 3'b001;
      TBL_SPRITE: we = 3'b010;
      TBL_COLOR:  we = 3'b100;
      default:    we = '0;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/ppu_write_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with register-array storage.
//   clk, reset      - clock, asynchronous active-high reset (empties the FIFO)
//   push, wr_data   - enqueue request and data (ignored when full)
//   pop             - dequeue request (ignored when empty)
//   rd_data         - head entry, read straight from the storage registers
//   full, empty     - occupancy flags
//   level           - occupancy, one bit wider than the pointers
module sync_fifo #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             push_ok;
  logic             pop_ok;

  // Counters carry one extra bit; the low bits are the wrapping pointers.
  assign level   = wr_cnt - rd_cnt;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push_ok) wr_cnt <= wr_cnt + 1'b1;
      if (pop_ok)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_cnt[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ppu_write_scheduler.sv
// ppu_write_scheduler: queues Avalon table writes and commits them to the PPU
// attr/sprite/color tables only during vertical blanking, one per cycle.
//   clk, reset     - 50 MHz clock, asynchronous active-high reset
//   av_chipselect, av_write, av_address[15:0], av_writedata[31:0]
//                  - Avalon slave write; address[9:8] table select, [7:0] entry
//   av_waitrequest - FIFO full, write not accepted
//   vcount         - current scanline
//   tbl_we[2:0]    - one-hot table write enable (attr, sprite, color)
//   tbl_addr, tbl_data - table write address/data (hold last value)
//   fifo_level     - queue occupancy
//   commit_done    - pulse with the last write of a drain inside the window
module ppu_write_scheduler
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned VBLANK_FIRST = VACTIVE,
  parameter int unsigned VBLANK_LAST  = VTOTAL - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   av_chipselect,
  input  logic                   av_write,
  input  logic [15:0]            av_address,
  input  logic [31:0]            av_writedata,
  output logic                   av_waitrequest,
  input  logic [9:0]             vcount,
  output logic [2:0]             tbl_we,
  output logic [7:0]             tbl_addr,
  output logic [31:0]            tbl_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   commit_done
);

  localparam int unsigned LW       = $clog2(DEPTH) + 1;
  localparam logic [9:0]  VB_FIRST = 10'(VBLANK_FIRST);
  localparam logic [9:0]  VB_LAST  = 10'(VBLANK_LAST);

  sched_state_t state;
  tbl_wr_t      wr_entry;
  tbl_wr_t      head;
  tbl_sel_t     av_sel;
  logic         accept;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic         window;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^av_address[15:10];

  assign av_sel   = tbl_sel_t'(av_address[9:8]);
  assign window   = (vcount >= VB_FIRST) && (vcount <= VB_LAST);
  assign accept   = av_chipselect & av_write & ~full;
  // Select 11 completes the handshake but is never stored.
  assign push     = accept & (av_sel != TBL_NONE);
  assign pop      = (state == DRAIN) & window & ~empty;
  assign wr_entry = '{sel: av_sel, addr: av_address[7:0], data: av_writedata};

  assign av_waitrequest = full;

  sync_fifo #(
    .WIDTH ($bits(tbl_wr_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tbl_we      <= '0;
      tbl_addr    <= '0;
      tbl_data    <= '0;
      commit_done <= 1'b0;
    end else begin
      tbl_we      <= '0;
      commit_done <= 1'b0;
      if (pop) begin
        tbl_we   <= sel_onehot(head.sel);
        tbl_addr <= head.addr;
        tbl_data <= head.data;
      end
      case (state)
        IDLE: begin
          if (window) state <= empty ? ARMED : DRAIN;
        end
        ARMED: begin
          if (!window)     state <= IDLE;
          else if (!empty) state <= DRAIN;
        end
        DRAIN: begin
          if (!window) begin
            state <= IDLE;
          end else if (empty) begin
            state <= ARMED;
          end else if ((fifo_level == LW'(1)) && !push) begin
            // Last entry leaves this cycle; the pulse lines up with its tbl_we.
            state       <= ARMED;
            commit_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
